// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs : reservation station for the ALU path of the tag-renamed OoO core.
//
// Buffers dispatched instructions (opcode, two operand value/tag pairs,
// immediate, destination tag), snoops the common data bus to wake pending
// operands and issues the lowest-index ready entry to the ALU.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   flush                 synchronous clear of every entry and of enIssue
//   enDisp, disp*         dispatch request and instruction fields
//   full                  all entries valid (combinational from valid bits)
//   enCdb, cdbTag, cdbData  common data bus broadcast
//   aluReady              ALU accepts an issue at this edge
//   enIssue, issue*       registered issue valid and instruction fields
// -----------------------------------------------------------------------------
module alu_rs #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int TAG_FREE = 0,
    parameter int OP_W     = 6,
    parameter int ENTRIES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enDisp,
    input  logic [OP_W-1:0]   dispOp,
    input  logic [DATA_W-1:0] dispDataO,
    input  logic [TAG_W-1:0]  dispTagO,
    input  logic [DATA_W-1:0] dispDataT,
    input  logic [TAG_W-1:0]  dispTagT,
    input  logic [DATA_W-1:0] dispImm,
    input  logic [TAG_W-1:0]  dispDest,
    output logic              full,
    input  logic              enCdb,
    input  logic [TAG_W-1:0]  cdbTag,
    input  logic [DATA_W-1:0] cdbData,
    input  logic              aluReady,
    output logic              enIssue,
    output logic [OP_W-1:0]   issueOp,
    output logic [DATA_W-1:0] issueDataO,
    output logic [DATA_W-1:0] issueDataT,
    output logic [DATA_W-1:0] issueImm,
    output logic [TAG_W-1:0]  issueDest
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [TAG_W-1:0] TAG_FREE_C = TAG_W'(TAG_FREE);

    // Entry storage
    logic [ENTRIES-1:0] valid_r;
    logic [OP_W-1:0]    op_r     [ENTRIES];
    logic [DATA_W-1:0]  data_o_r [ENTRIES];
    logic [TAG_W-1:0]   tag_o_r  [ENTRIES];
    logic [DATA_W-1:0]  data_t_r [ENTRIES];
    logic [TAG_W-1:0]   tag_t_r  [ENTRIES];
    logic [DATA_W-1:0]  imm_r    [ENTRIES];
    logic [TAG_W-1:0]   dest_r   [ENTRIES];

    // Issue registers
    logic              en_issue_r;
    logic [OP_W-1:0]   issue_op_r;
    logic [DATA_W-1:0] issue_data_o_r;
    logic [DATA_W-1:0] issue_data_t_r;
    logic [DATA_W-1:0] issue_imm_r;
    logic [TAG_W-1:0]  issue_dest_r;

    // Combinational helpers
    logic [ENTRIES-1:0] ready_s;
    logic [ENTRIES-1:0] wake_o_s;
    logic [ENTRIES-1:0] wake_t_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               sel_found_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               full_s;
    logic               cdb_live_s;
    logic               disp_fire_s;
    logic               issue_fire_s;
    logic [DATA_W-1:0]  disp_data_o_s;
    logic [TAG_W-1:0]   disp_tag_o_s;
    logic [DATA_W-1:0]  disp_data_t_s;
    logic [TAG_W-1:0]   disp_tag_t_s;

    // Per-entry readiness and CDB tag match (a TAG_FREE broadcast never matches)
    always_comb begin
        ready_s    = '0;
        wake_o_s   = '0;
        wake_t_s   = '0;
        cdb_live_s = enCdb && (cdbTag != TAG_FREE_C);
        for (int i = 0; i < ENTRIES; i++) begin
            ready_s[i]  = valid_r[i] && (tag_o_r[i] == TAG_FREE_C) && (tag_t_r[i] == TAG_FREE_C);
            wake_o_s[i] = valid_r[i] && cdb_live_s && (tag_o_r[i] == cdbTag);
            wake_t_s[i] = valid_r[i] && cdb_live_s && (tag_t_r[i] == cdbTag);
        end
    end

    // Priority pick: lowest-index ready entry and lowest-index free entry.
    // Scanning downward lets the lowest index overwrite earlier hits.
    always_comb begin
        sel_idx_s   = '0;
        sel_found_s = 1'b0;
        free_idx_s  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ready_s[i]) begin
                sel_idx_s   = IDX_W'(i);
                sel_found_s = 1'b1;
            end else begin
                sel_idx_s   = sel_idx_s;
                sel_found_s = sel_found_s;
            end
            if (!valid_r[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Handshakes and dispatch-time bypass of an operand being broadcast now
    always_comb begin
        full_s       = &valid_r;
        disp_fire_s  = enDisp && !full_s;
        issue_fire_s = sel_found_s && aluReady;
        if (cdb_live_s && (dispTagO == cdbTag)) begin
            disp_data_o_s = cdbData;
            disp_tag_o_s  = TAG_FREE_C;
        end else begin
            disp_data_o_s = dispDataO;
            disp_tag_o_s  = dispTagO;
        end
        if (cdb_live_s && (dispTagT == cdbTag)) begin
            disp_data_t_s = cdbData;
            disp_tag_t_s  = TAG_FREE_C;
        end else begin
            disp_data_t_s = dispDataT;
            disp_tag_t_s  = dispTagT;
        end
    end

    // Entry array: wakeup, issue de-allocation and dispatch allocation.
    // The dispatched slot is invalid before the edge, so it can never be the
    // issuing slot nor a wakeup target in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_r[i]     <= '0;
                data_o_r[i] <= '0;
                tag_o_r[i]  <= '0;
                data_t_r[i] <= '0;
                tag_t_r[i]  <= '0;
                imm_r[i]    <= '0;
                dest_r[i]   <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wake_o_s[i]) begin
                    data_o_r[i] <= cdbData;
                    tag_o_r[i]  <= TAG_FREE_C;
                end
                if (wake_t_s[i]) begin
                    data_t_r[i] <= cdbData;
                    tag_t_r[i]  <= TAG_FREE_C;
                end
                if (issue_fire_s && (sel_idx_s == IDX_W'(i))) begin
                    valid_r[i] <= 1'b0;
                end
                if (disp_fire_s && (free_idx_s == IDX_W'(i))) begin
                    valid_r[i]  <= 1'b1;
                    op_r[i]     <= dispOp;
                    data_o_r[i] <= disp_data_o_s;
                    tag_o_r[i]  <= disp_tag_o_s;
                    data_t_r[i] <= disp_data_t_s;
                    tag_t_r[i]  <= disp_tag_t_s;
                    imm_r[i]    <= dispImm;
                    dest_r[i]   <= dispDest;
                end
            end
        end
    end

    // Issue registers: fields hold between issues, enIssue qualifies them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_issue_r     <= 1'b0;
            issue_op_r     <= '0;
            issue_data_o_r <= '0;
            issue_data_t_r <= '0;
            issue_imm_r    <= '0;
            issue_dest_r   <= '0;
        end else if (flush) begin
            en_issue_r <= 1'b0;
        end else if (issue_fire_s) begin
            en_issue_r     <= 1'b1;
            issue_op_r     <= op_r[sel_idx_s];
            issue_data_o_r <= data_o_r[sel_idx_s];
            issue_data_t_r <= data_t_r[sel_idx_s];
            issue_imm_r    <= imm_r[sel_idx_s];
            issue_dest_r   <= dest_r[sel_idx_s];
        end else begin
            en_issue_r <= 1'b0;
        end
    end

    assign full       = full_s;
    assign enIssue    = en_issue_r;
    assign issueOp    = issue_op_r;
    assign issueDataO = issue_data_o_r;
    assign issueDataT = issue_data_t_r;
    assign issueImm   = issue_imm_r;
    assign issueDest  = issue_dest_r;

endmodule

// File: tb/tb_alu_rs.sv
// -----------------------------------------------------------------------------
// tb_alu_rs : self-checking bench for alu_rs. Table of single-dispatch
// vectors, directed multi-cycle sequences, then randomized traffic compared
// against a behavioural model of the station (array of entry records).
// -----------------------------------------------------------------------------
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst, flush, enDisp, enCdb, aluReady;
    logic [5:0]  dispOp;
    logic [31:0] dispDataO, dispDataT, dispImm, cdbData;
    logic [3:0]  dispTagO, dispTagT, dispDest, cdbTag;
    logic        full, enIssue;
    logic [5:0]  issueOp;
    logic [31:0] issueDataO, issueDataT, issueImm;
    logic [3:0]  issueDest;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enDisp(enDisp), .dispOp(dispOp), .dispDataO(dispDataO), .dispTagO(dispTagO),
        .dispDataT(dispDataT), .dispTagT(dispTagT), .dispImm(dispImm), .dispDest(dispDest),
        .full(full), .enCdb(enCdb), .cdbTag(cdbTag), .cdbData(cdbData),
        .aluReady(aluReady), .enIssue(enIssue), .issueOp(issueOp),
        .issueDataO(issueDataO), .issueDataT(issueDataT), .issueImm(issueImm),
        .issueDest(issueDest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enDisp = 1'b0; enCdb = 1'b0; flush = 1'b0;
        dispOp = '0; dispDataO = '0; dispTagO = '0; dispDataT = '0; dispTagT = '0;
        dispImm = '0; dispDest = '0; cdbTag = '0; cdbData = '0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] a, input logic [3:0] ta,
                        input logic [31:0] b, input logic [3:0] tb_, input logic [31:0] imm,
                        input logic [3:0] dest);
        enDisp = 1'b1; dispOp = op; dispDataO = a; dispTagO = ta;
        dispDataT = b; dispTagT = tb_; dispImm = imm; dispDest = dest;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // ---------------- table of single-dispatch vectors ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;  logic [3:0] ta;
        logic [31:0] b;  logic [3:0] tb_;
        logic [31:0] imm; logic [3:0] dest;
        logic        cdb; logic [3:0] ctag; logic [31:0] cdata;
        logic        exp_en; logic [31:0] exp_a; logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[7];

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          v;
        logic [5:0]  op;
        logic [31:0] a;  logic [3:0] ta;
        logic [31:0] b;  logic [3:0] tb_;
        logic [31:0] imm; logic [3:0] dest;
    } ent_t;

    ent_t        m[8];
    bit          m_en;
    ent_t        m_out;

    function automatic bit m_full();
        for (int i = 0; i < 8; i++) if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge of the station, from the inputs currently applied
    task automatic model_edge();
        int sel = -1;
        int slot = -1;
        if (flush) begin
            for (int i = 0; i < 8; i++) m[i].v = 1'b0;
            m_en = 1'b0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (sel < 0 && m[i].v && m[i].ta == 4'd0 && m[i].tb_ == 4'd0) sel = i;
            if (slot < 0 && !m[i].v) slot = i;
        end
        if (sel >= 0 && aluReady) begin
            m_out = m[sel];
            m[sel].v = 1'b0;
            m_en = 1'b1;
        end else begin
            m_en = 1'b0;
        end
        if (enCdb && cdbTag != 4'd0) begin
            for (int i = 0; i < 8; i++) begin
                if (m[i].v && m[i].ta == cdbTag) begin m[i].a = cdbData; m[i].ta = 4'd0; end
                if (m[i].v && m[i].tb_ == cdbTag) begin m[i].b = cdbData; m[i].tb_ = 4'd0; end
            end
        end
        if (enDisp && slot >= 0) begin
            m[slot].v = 1'b1;
            m[slot].op = dispOp; m[slot].imm = dispImm; m[slot].dest = dispDest;
            m[slot].a = dispDataO; m[slot].ta = dispTagO;
            m[slot].b = dispDataT; m[slot].tb_ = dispTagT;
            if (enCdb && cdbTag != 4'd0 && dispTagO == cdbTag) begin
                m[slot].a = cdbData; m[slot].ta = 4'd0;
            end
            if (enCdb && cdbTag != 4'd0 && dispTagT == cdbTag) begin
                m[slot].b = cdbData; m[slot].tb_ = 4'd0;
            end
        end
    endtask

    initial begin
        idle();
        aluReady = 1'b1;
        rst = 1'b1;
        tick(); tick();
        check("reset_enIssue", {31'd0, enIssue}, 32'd0);
        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_dataO", issueDataO, 32'd0);
        check("reset_dest", {28'd0, issueDest}, 32'd0);
        rst = 1'b0;
        tick();

        // Ready path: minimum latency and single-cycle enIssue
        disp(6'd3, 32'h10, 4'd0, 32'h20, 4'd0, 32'h0, 4'd5);
        tick();
        idle();
        check("ready_no_early_issue", {31'd0, enIssue}, 32'd0);
        tick();
        check("ready_en", {31'd0, enIssue}, 32'd1);
        check("ready_op", {26'd0, issueOp}, 32'd3);
        check("ready_dataO", issueDataO, 32'h10);
        check("ready_dataT", issueDataT, 32'h20);
        check("ready_dest", {28'd0, issueDest}, 32'd5);
        tick();
        check("ready_en_drop", {31'd0, enIssue}, 32'd0);

        // Asynchronous reset mid-cycle after three dispatches
        aluReady = 1'b0;
        disp(6'd2, 32'h111, 4'd0, 32'h222, 4'd0, 32'h333, 4'd4); tick();
        disp(6'd5, 32'h1, 4'd0, 32'h2, 4'd0, 32'h3, 4'd6); tick();
        disp(6'd6, 32'h4, 4'd0, 32'h5, 4'd0, 32'h6, 4'd7); tick();
        idle();
        aluReady = 1'b1;
        tick();
        check("pre_rst_en", {31'd0, enIssue}, 32'd1);
        check("pre_rst_dataO", issueDataO, 32'h111);
        #2 rst = 1'b1;
        #1;
        check("rst_async_en", {31'd0, enIssue}, 32'd0);
        check("rst_async_full", {31'd0, full}, 32'd0);
        check("rst_async_op", {26'd0, issueOp}, 32'd0);
        check("rst_async_dataO", issueDataO, 32'd0);
        check("rst_async_imm", issueImm, 32'd0);
        check("rst_async_dest", {28'd0, issueDest}, 32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        disp(6'd9, 32'h99, 4'd0, 32'h98, 4'd0, 32'h97, 4'd8);
        tick();
        idle();
        tick();
        check("post_rst_en", {31'd0, enIssue}, 32'd1);
        check("post_rst_dest", {28'd0, issueDest}, 32'd8);
        tick();
        check("post_rst_old_gone", {31'd0, enIssue}, 32'd0);

        // Wakeup: pending operand waits, then issues two edges after broadcast
        disp(6'd1, 32'h1, 4'd7, 32'h2, 4'd0, 32'h0, 4'd3);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wake_wait", {31'd0, enIssue}, 32'd0);
        end
        enCdb = 1'b1; cdbTag = 4'd7; cdbData = 32'hABCD;
        tick();
        idle();
        check("wake_no_same_cycle", {31'd0, enIssue}, 32'd0);
        tick();
        check("wake_en", {31'd0, enIssue}, 32'd1);
        check("wake_dataO", issueDataO, 32'hABCD);
        check("wake_dataT", issueDataT, 32'h2);

        // Table-driven single dispatches (bypass, TAG_FREE broadcast, etc.)
        vecs[0] = '{6'd3, 32'h10, 4'd0, 32'h20, 4'd0, 32'h0, 4'd5, 1'b0, 4'd0, 32'h0, 1'b1, 32'h10, 32'h20};
        vecs[1] = '{6'd1, 32'h1, 4'd0, 32'h2, 4'd9, 32'h7, 4'd2, 1'b1, 4'd9, 32'h55, 1'b1, 32'h1, 32'h55};
        vecs[2] = '{6'd4, 32'h3, 4'd6, 32'h4, 4'd0, 32'h8, 4'd1, 1'b1, 4'd6, 32'hBEEF, 1'b1, 32'hBEEF, 32'h4};
        vecs[3] = '{6'd7, 32'h5, 4'd4, 32'h6, 4'd4, 32'h9, 4'd9, 1'b1, 4'd4, 32'h1234, 1'b1, 32'h1234, 32'h1234};
        vecs[4] = '{6'd8, 32'hAA, 4'd0, 32'hBB, 4'd0, 32'h1, 4'd3, 1'b1, 4'd0, 32'hFFFF, 1'b1, 32'hAA, 32'hBB};
        vecs[5] = '{6'd2, 32'h1, 4'd5, 32'h2, 4'd0, 32'h1, 4'd3, 1'b1, 4'd6, 32'h77, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{6'h3F, 32'hFFFFFFFF, 4'd0, 32'h0, 4'd0, 32'hDEADBEEF, 4'd15, 1'b0, 4'd0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h0};
        for (int k = 0; k < 7; k++) begin
            do_flush();
            disp(vecs[k].op, vecs[k].a, vecs[k].ta, vecs[k].b, vecs[k].tb_, vecs[k].imm, vecs[k].dest);
            enCdb = vecs[k].cdb; cdbTag = vecs[k].ctag; cdbData = vecs[k].cdata;
            tick();
            idle();
            tick();
            check($sformatf("vec%0d_en", k), {31'd0, enIssue}, {31'd0, vecs[k].exp_en});
            if (vecs[k].exp_en) begin
                check($sformatf("vec%0d_op", k), {26'd0, issueOp}, {26'd0, vecs[k].op});
                check($sformatf("vec%0d_dataO", k), issueDataO, vecs[k].exp_a);
                check($sformatf("vec%0d_dataT", k), issueDataT, vecs[k].exp_b);
                check($sformatf("vec%0d_imm", k), issueImm, vecs[k].imm);
                check($sformatf("vec%0d_dest", k), {28'd0, issueDest}, {28'd0, vecs[k].dest});
            end
        end

        // Full and back-pressure
        do_flush();
        aluReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(6'd1, 32'(i), 4'd3, 32'h0, 4'd0, 32'h0, 4'(i));
            tick();
        end
        check("full_set", {31'd0, full}, 32'd1);
        disp(6'd1, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 4'd15);
        tick();
        check("full_ignore", {31'd0, full}, 32'd1);
        idle();
        enCdb = 1'b1; cdbTag = 4'd3; cdbData = 32'h77;
        aluReady = 1'b1;
        tick();
        idle();
        check("full_wake_no_issue", {31'd0, enIssue}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("bp_en", {31'd0, enIssue}, 32'd1);
            check("bp_order", {28'd0, issueDest}, 32'(i));
            check("bp_dataO", issueDataO, 32'h77);
            if (i == 0) check("bp_full_drop", {31'd0, full}, 32'd0);
        end
        tick();
        check("bp_ninth_absent", {31'd0, enIssue}, 32'd0);

        // Flush with four valid entries, one ready
        aluReady = 1'b0;
        disp(6'd1, 32'h1, 4'd0, 32'h1, 4'd0, 32'h0, 4'd1); tick();
        for (int i = 0; i < 3; i++) begin
            disp(6'd1, 32'h1, 4'd2, 32'h1, 4'd0, 32'h0, 4'd2); tick();
        end
        idle();
        aluReady = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_en", {31'd0, enIssue}, 32'd0);
        check("flush_full", {31'd0, full}, 32'd0);
        enCdb = 1'b1; cdbTag = 4'd2; cdbData = 32'h5;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_issue", {31'd0, enIssue}, 32'd0);
        end

        // Randomized traffic against the behavioural model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = '{1'b0, '0, '0, '0, '0, '0, '0, '0};
        m_en = 1'b0;
        m_out = '{1'b0, '0, '0, '0, '0, '0, '0, '0};
        for (int c = 0; c < 1500; c++) begin
            enDisp = ($urandom_range(0, 9) < 6);
            dispOp = 6'($urandom);
            dispDataO = $urandom; dispTagO = 4'($urandom_range(0, 3));
            dispDataT = $urandom; dispTagT = 4'($urandom_range(0, 3));
            dispImm = $urandom; dispDest = 4'($urandom);
            enCdb = $urandom_range(0, 1) == 1;
            cdbTag = 4'($urandom_range(0, 3)); cdbData = $urandom;
            aluReady = ($urandom_range(0, 9) < 5);
            flush = ($urandom_range(0, 63) == 0);
            check("rnd_full", {31'd0, full}, {31'd0, m_full()});
            model_edge();
            tick();
            check("rnd_en", {31'd0, enIssue}, {31'd0, m_en});
            check("rnd_op", {26'd0, issueOp}, {26'd0, m_out.op});
            check("rnd_dataO", issueDataO, m_out.a);
            check("rnd_dataT", issueDataT, m_out.b);
            check("rnd_imm", issueImm, m_out.imm);
            check("rnd_dest", {28'd0, issueDest}, {28'd0, m_out.dest});
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the ALU path in the tag-renamed out-of-order core.
- Sits directly downstream of the regfile. Dispatch presents the regfile's operand data/tag pairs plus a destination tag; the station buffers the instruction.
- Snoops the common data bus (the same broadcast that writes the regfile) to wake pending operands.
- Issues ready instructions to the ALU, oldest-slot-first by index.

Parameters:
- DATA_W, 32, operand/result width.
- TAG_W, 4, tag width.
- TAG_FREE, 0, tag value meaning "operand value valid".
- OP_W, 6, internal opcode width.
- ENTRIES, 8, station depth (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  sync clear of all entries (mispredict).
- enDisp  in  1  dispatch request this cycle.
- dispOp  in  OP_W  opcode.
- dispDataO  in  DATA_W  operand 1 value.
- dispTagO  in  TAG_W  operand 1 tag.
- dispDataT  in  DATA_W  operand 2 value.
- dispTagT  in  TAG_W  operand 2 tag.
- dispImm  in  DATA_W  immediate, carried through.
- dispDest  in  TAG_W  destination tag of the instruction.
- full  out  1  no free entry (combinational from registered valid bits).
- enCdb  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  broadcast tag.
- cdbData  in  DATA_W  broadcast value.
- aluReady  in  1  ALU accepts an issue this edge.
- enIssue  out  1  issue valid (registered).
- issueOp  out  OP_W  registered.
- issueDataO  out  DATA_W  registered.
- issueDataT  out  DATA_W  registered.
- issueImm  out  DATA_W  registered.
- issueDest  out  TAG_W  registered.

Behaviour:
Reset and flush:
- Reset (async, rst high): all entry valid bits 0; enIssue and all issue outputs 0; full 0. Holds while rst high; rst mid-operation discards all entries and any in-flight issue.
- flush high at an edge: all valid 0, enIssue 0. Dispatch, wakeup and issue in that cycle are discarded. flush outranks everything except rst.

Entry state:
- valid, op, dataO, tagO, dataT, tagT, imm, dest.
- An operand is ready iff its tag == TAG_FREE.
- An entry is ready iff valid and both operands are ready.

Dispatch:
- Accepted at an edge iff enDisp && !full. The lowest-index invalid entry is written.
- enDisp while full: ignored silently. Upstream must hold the request.
- Dispatch bypass: if enCdb && cdbTag == dispTagX && dispTagX != TAG_FREE, store cdbData and TAG_FREE for that operand. The two operands are checked independently.

Wakeup:
- Every edge, for each valid entry and each operand with tag != TAG_FREE: if enCdb && cdbTag == tag, then data <= cdbData and tag <= TAG_FREE.
- A broadcast of TAG_FREE never matches.

Select and issue:
- Select is combinational on registered state only: the lowest-index ready entry.
- An entry woken or dispatched at edge N is selectable at edge N+1 at the earliest. There is no same-cycle wakeup-to-issue.
- At an edge where some entry is ready and aluReady = 1:
  - the selected entry's fields load into the issue registers;
  - enIssue <= 1;
  - the entry's valid <= 0.
- Otherwise enIssue <= 0. Issue registers keep their previous value; only enIssue qualifies them.
- Minimum latency: dispatch with both operands ready at edge N, then enIssue high in the cycle after edge N+1.
- Same edge issue from slot k and dispatch: the dispatch uses full as evaluated before the edge, so the freed slot k is reusable only from the next edge.
- Same edge issue and wakeup of a different entry: both take effect.

full:
- Asserted iff all ENTRIES valid bits are 1.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after 3 dispatches → enIssue, full and all issue outputs 0 immediately; after release, a dispatch with both tags TAG_FREE issues with enIssue 1 two edges later.
- Ready path: dispatch op=3, dataO=0x10, dataT=0x20, tags 0, dest=5, aluReady=1 → next-next cycle enIssue=1, issueDataO=0x10, issueDataT=0x20, issueDest=5; following cycle enIssue=0.
- Wakeup: dispatch tagO=7, tagT=0; hold 3 cycles → no issue. Broadcast enCdb=1, cdbTag=7, cdbData=0xABCD → issue 2 edges later with issueDataO=0xABCD.
- Dispatch bypass: dispatch tagT=9 in the same cycle as a CDB broadcast of tag 9, data 0x55 → entry issues with issueDataT=0x55 without any further broadcast.
- Full and back-pressure: fill 8 entries with tagO=3, aluReady=0 → full=1, a 9th enDisp is ignored. Broadcast tag 3 and raise aluReady → slots 0..7 issue in index order on consecutive edges; full drops after the first issue.
- Flush: with 4 entries valid and one ready, pulse flush → enIssue 0 next cycle, full 0, and no entry issues on later broadcasts.
